// File: rtl/mux2_stim_pkg.sv
// Shared types and constants for the mux2 stimulus generator.
// The LFSR constants are used only when STIM_LFSR_EN is defined.
package mux2_stim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // x^8+x^6+x^5+x^4+1, shifting left: feedback from bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/stim_toggle_chan.sv
// One square-wave channel: a half-period counter and an output register.
// The output toggles every 'half' enabled cycles.
module stim_toggle_chan #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] half,
    output logic         tick,
    output logic         q
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == half - ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            q   <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            q   <= 1'b0;
        end else if (tick) begin
            cnt <= '0;
            q   <= ~q;
        end else if (en) begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/mux2_stim_gen.sv
// Start/stop controlled square-wave generator driving a mux2 under test.
// Optional feature: define STIM_LFSR_EN to drive b from an 8-bit LFSR.
//
//  state | meaning
//  IDLE  | outputs hold; waits for start (stop blocks it)
//  RUN   | channels count and toggle; busy=1
//  DONE  | one-cycle done pulse, outputs hold
module mux2_stim_gen
    import mux2_stim_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int RUN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] half_a,
    input  logic [CNT_W-1:0] half_b,
    input  logic [CNT_W-1:0] half_s,
    input  logic [RUN_W-1:0] run_len,
    output logic             a,
    output logic             b,
    output logic             s1,
    output logic             y_exp,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] HALF_ONE = CNT_W'(1);
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] half_a_r, half_b_r, half_s_r;
    logic [RUN_W-1:0] run_len_r, run_cnt;
    logic             launch, run_en, last;
    logic             a_tick, b_tick, s_tick, b_q;

    assign launch = (state == IDLE) && start && !stop;
    assign run_en = (state == RUN);
    assign last   = (run_len_r != '0) && (run_cnt == run_len_r - RUN_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            half_a_r  <= '0;
            half_b_r  <= '0;
            half_s_r  <= '0;
            run_len_r <= '0;
            run_cnt   <= '0;
        end else begin
            state <= state_nx;
            if (launch) begin
                half_a_r  <= (half_a == '0) ? HALF_ONE : half_a;
                half_b_r  <= (half_b == '0) ? HALF_ONE : half_b;
                half_s_r  <= (half_s == '0) ? HALF_ONE : half_s;
                run_len_r <= run_len;
                run_cnt   <= '0;
            end else if (run_en && (run_cnt != '1)) begin
                run_cnt <= run_cnt + RUN_ONE;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (launch) state_nx = RUN;
            RUN:     if (stop || last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    stim_toggle_chan #(.W(CNT_W)) u_chan_a (
        .clk(clk), .rst_n(rst_n), .clr(launch), .en(run_en),
        .half(half_a_r), .tick(a_tick), .q(a)
    );
    stim_toggle_chan #(.W(CNT_W)) u_chan_b (
        .clk(clk), .rst_n(rst_n), .clr(launch), .en(run_en),
        .half(half_b_r), .tick(b_tick), .q(b_q)
    );
    stim_toggle_chan #(.W(CNT_W)) u_chan_s (
        .clk(clk), .rst_n(rst_n), .clr(launch), .en(run_en),
        .half(half_s_r), .tick(s_tick), .q(s1)
    );

`ifdef STIM_LFSR_EN
    logic [7:0] lfsr;
    logic       unused_chan;
    assign unused_chan = ^{a_tick, s_tick, b_q};

    // b's half-period events step the LFSR instead of toggling b
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      lfsr <= LFSR_SEED;
        else if (launch) lfsr <= LFSR_SEED;
        else if (b_tick) lfsr <= lfsr_next(lfsr);
    end
    assign b = lfsr[0];
`else
    logic unused_chan;
    assign unused_chan = ^{a_tick, s_tick, b_tick};
    assign b = b_q;
`endif

    assign y_exp = s1 ? b : a;

endmodule
